// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: unified word store with
// programmable wait states, a one-cycle MemReady pulse and a coincident MemErr.
//
//   state | meaning
//   IDLE  | waiting for MemRead/MemWrite; request fields latched on acceptance
//   BUSY  | counting down wait states; access performed as the count hits 0
//   DONE  | MemReady (and MemErr if faulted) high for this one cycle
module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemErr
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              acc_rd;
  logic              acc_wr;
  logic              acc_err;
  logic              acc_go;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [ADDR_W-3:0] acc_word;
  logic [IDX_W-1:0]  acc_idx;

  // With zero wait states the access happens on the accepting edge, so the
  // live inputs are used in IDLE and the latched copy everywhere else.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr  = Addr;
      acc_wdata = WriteData;
      acc_rd    = MemRead;
      acc_wr    = MemWrite;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
    end
    acc_word = acc_addr[ADDR_W-1:2];
    acc_idx  = acc_addr[IDX_W+1:2];
    acc_err  = (acc_addr[1:0] != 2'b00) ||
               (acc_word >= (ADDR_W-2)'(DEPTH_WORDS)) ||
               (acc_rd && acc_wr);
    if (state_q == IDLE)
      acc_go = (MemRead || MemWrite) && (WAIT_CYCLES == 0);
    else
      acc_go = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ReadData <= '0;
      MemReady <= 1'b0;
      MemErr   <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      MemErr   <= 1'b0;
      if (acc_go) begin
        MemReady <= 1'b1;
        MemErr   <= acc_err;
        if (acc_rd)
          ReadData <= acc_err ? '0 : mem_q[acc_idx];
      end
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            addr_q  <= Addr;
            wdata_q <= WriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1))
            state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store is deliberately left out of reset; an aborted write never lands.
  always_ff @(posedge clk) begin
    if (reset && acc_go && acc_wr && !acc_err)
      mem_q[acc_idx] <= acc_wdata;
  end

endmodule
